l2cache_flush_engine: RTL

//  Parametrised flush/initialisation sequencer for an N-way set-associative L2 cache.

---
 rtl/l2cache_flush_pkg.sv | 25 ++
 rtl/l2cache_flush_engine_if.sv | 48 ++++
 rtl/l2cache_flush_engine.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/l2cache_flush_pkg.sv
// Shared types for the L2 flush/initialisation sequencer: FSM states and flush modes.
package l2cache_flush_pkg;

    typedef enum logic [3:0] {
        State_Reset      = 4'd0,
        State_ResetWrite = 4'd1,
        State_Idle       = 4'd2,
        State_SetupAddr  = 4'd3,
        State_Check      = 4'd4,
        State_WriteReq   = 4'd5,
        State_WaitResp   = 4'd6,
        State_Invalidate = 4'd7,
        State_Done       = 4'd8
    } state_t;

    localparam logic [1:0] FLUSH_ALL   = 2'd0;
    localparam logic [1:0] FLUSH_LINE  = 2'd1;
    localparam logic [1:0] FLUSH_RANGE = 2'd2;

    // The reserved encoding behaves exactly like a single-line flush.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? FLUSH_LINE : m;
    endfunction

endpackage

// File: rtl/l2cache_flush_engine_if.sv
// Request, tag/data RAM and write-back signals of the L2 flush engine.
interface l2cache_flush_engine_if #(
    parameter int abus    = 48,
    parameter int lenbits = 16,
    parameter int waybits = 2
) ();
    logic               req_valid;
    logic [1:0]         req_mode;
    logic [abus-1:0]    req_addr;
    logic [lenbits-1:0] req_len;
    logic               req_ready;

    logic               line_rd;
    logic               line_inv;
    logic [abus-1:0]    line_addr;
    logic [waybits-1:0] line_way;
    logic               line_valid;
    logic               line_dirty;
    logic               line_hit;
    logic [abus-1:0]    line_tag_addr;

    logic               wb_valid;
    logic [abus-1:0]    wb_addr;
    logic               wb_ready;
    logic               wb_resp;
    logic               wb_err;

    logic               done;
    logic               err;

    // Engine side
    modport master (
        input  req_valid, req_mode, req_addr, req_len,
        input  line_valid, line_dirty, line_hit, line_tag_addr,
        input  wb_ready, wb_resp, wb_err,
        output req_ready, line_rd, line_inv, line_addr, line_way,
        output wb_valid, wb_addr, done, err
    );

    // Arbiter / RAM / bus side
    modport slave (
        output req_valid, req_mode, req_addr, req_len,
        output line_valid, line_dirty, line_hit, line_tag_addr,
        output wb_ready, wb_resp, wb_err,
        input  req_ready, line_rd, line_inv, line_addr, line_way,
        input  wb_valid, wb_addr, done, err
    );
endinterface

// File: rtl/l2cache_flush_engine.sv
// Flush/initialisation sequencer for an N-way L2: walks sets/ways, writes back dirty
// lines, invalidates, and reports a sticky write-back error per flush.
module l2cache_flush_engine
    import l2cache_flush_pkg::*;
#(
    parameter int abus    = 48,
    parameter int lnbits  = 5,
    parameter int ibits   = 9,
    parameter int waybits = 2,
    parameter int lenbits = 16
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    l2cache_flush_engine_if.master bus
);

    localparam int CW = ibits + waybits;
    localparam logic [abus-1:0] LINE_MASK = {{(abus-lnbits){1'b0}}, {lnbits{1'b1}}};

    typedef struct packed {
        state_t             state;
        logic [1:0]         mode;
        logic [abus-1:0]    addr;
        logic [lenbits-1:0] len;
        logic [lenbits-1:0] line_off;
        logic [CW-1:0]      cnt;
        logic [abus-1:0]    wb_addr;
        logic               err;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        state:    State_Reset,
        mode:     FLUSH_ALL,
        addr:     '0,
        len:      '0,
        line_off: '0,
        cnt:      '0,
        wb_addr:  '0,
        err:      1'b0
    };

    regs_t r, v;

    logic [1:0]      req_mode_n;
    logic            sel;
    logic            way_last;
    logic            flush_last;
    logic            advance;
    logic [abus-1:0] set_addr;
    logic [abus-1:0] off_addr;
    logic [abus-1:0] line_addr_c;

    always_comb begin
        v       = r;
        advance = 1'b0;

        req_mode_n = norm_mode(bus.req_mode);
        sel        = bus.line_valid & ((r.mode == FLUSH_ALL) | bus.line_hit);
        way_last   = &r.cnt[waybits-1:0];
        flush_last = way_last &&
                     ((r.mode == FLUSH_ALL) ? (&r.cnt)
                                            : (r.line_off == (r.len - lenbits'(1))));

        // Set-walk address has zero tag bits; line flushes add the offset modulo 2^abus.
        set_addr = '0;
        set_addr[lnbits +: ibits] = r.cnt[CW-1:waybits];
        off_addr = r.addr + (abus'(r.line_off) << lnbits);
        if (r.mode == FLUSH_ALL || r.state == State_Reset || r.state == State_ResetWrite)
            line_addr_c = set_addr;
        else
            line_addr_c = off_addr;

        case (r.state)
            State_Reset: begin
                v.state = State_ResetWrite;
            end
            State_ResetWrite: begin
                v.cnt = r.cnt + CW'(1);
                if (&r.cnt)
                    v.state = State_Idle;
            end
            State_Idle: begin
                if (bus.req_valid) begin
                    v.mode     = req_mode_n;
                    v.addr     = bus.req_addr & ~LINE_MASK;
                    v.len      = (req_mode_n == FLUSH_LINE) ? lenbits'(1) : bus.req_len;
                    v.cnt      = '0;
                    v.line_off = '0;
                    v.err      = 1'b0;
                    if (req_mode_n == FLUSH_RANGE && bus.req_len == '0)
                        v.state = State_Done;
                    else
                        v.state = State_SetupAddr;
                end
            end
            State_SetupAddr: begin
                v.state = State_Check;
            end
            State_Check: begin
                if (sel && bus.line_dirty) begin
                    v.wb_addr = bus.line_tag_addr;
                    v.state   = State_WriteReq;
                end else if (sel) begin
                    v.state = State_Invalidate;
                end else begin
                    advance = 1'b1;
                end
            end
            State_WriteReq: begin
                if (bus.wb_ready)
                    v.state = State_WaitResp;
            end
            State_WaitResp: begin
                // An errored write-back still drops the line; the error is only reported.
                if (bus.wb_resp) begin
                    v.err   = r.err | bus.wb_err;
                    v.state = State_Invalidate;
                end
            end
            State_Invalidate: begin
                advance = 1'b1;
            end
            State_Done: begin
                v.state = State_Idle;
            end
            default: begin
                v.state = State_Reset;
            end
        endcase

        if (advance) begin
            if (flush_last) begin
                v.state = State_Done;
            end else begin
                v.cnt   = r.cnt + CW'(1);
                v.state = State_SetupAddr;
                if (way_last)
                    v.line_off = r.line_off + lenbits'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)
            r <= REGS_RESET;
        else
            r <= v;
    end

    assign bus.req_ready = (r.state == State_Idle);
    assign bus.line_rd   = (r.state == State_SetupAddr);
    assign bus.line_inv  = (r.state == State_ResetWrite) || (r.state == State_Invalidate);
    assign bus.line_addr = line_addr_c;
    assign bus.line_way  = r.cnt[waybits-1:0];
    assign bus.wb_valid  = (r.state == State_WriteReq);
    assign bus.wb_addr   = r.wb_addr;
    assign bus.done      = (r.state == State_Done);
    assign bus.err       = r.err;

endmodule
